uart_rx_byte: RTL and testbench

- Serial receive front end for the 32-bit-word UART path.
- Sits between the board RX pin (sig_rx, after the clock buffer and wrapper) and the byte-to-word joiner inside the top-level test design.
- Oversamples the asynchronous serial line and recovers 8N1 frames, LSB first.
- Presents each received byte on a valid/ready holding register. Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_byte.sv | 154 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
// Holds the receiver state encoding, default line settings and the
// helper that turns a clock frequency and baud rate into clocks per bit.
package uart_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int BYTE_WIDTH     = 8;
    localparam int CLOCK_FREQ_DEF = 200_000_000;
    localparam int BAUD_RATE_DEF  = 115200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines come out of reset
// looking idle rather than producing a spurious edge.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops; the second flop is the clean output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a valid/ready holding register.
// The line is oversampled at the system clock; the start bit is
// confirmed at its midpoint and each later bit is sampled one bit period
// after the previous sample. Framing errors and dropped bytes are flagged
// with single-cycle pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = BYTE_WIDTH,
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEF,
    parameter int BAUD_RATE  = BAUD_RATE_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sig_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;

    rx_state_t             state, state_next;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;
    logic [IDX_W-1:0]      bit_idx, idx_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  byte_done;
    logic                  stop_low;
    logic                  accept;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (sig_in),
        .q    (rx_s)
    );

    // Register the frame state machine, its counters and the shift register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            bit_idx <= idx_next;
            shift   <= shift_next;
        end
    end

    // Decide the next frame state; the counter restarts on every transition.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt + CNT_W'(1);
        idx_next   = bit_idx;
        shift_next = shift;
        byte_done  = 1'b0;
        stop_low   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_low   = 1'b1;
                        state_next = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign accept = data_valid && data_ready;

    // Holding register: a finished byte loads if the slot is free or being
    // emptied this cycle, otherwise it is dropped and flagged as an overrun.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_low;
            overrun     <= 1'b0;
            if (byte_done) begin
                if (!data_valid || accept) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
// A negedge monitor logs accepted bytes and pulse cycles; the main
// sequence drives frames and checks the log against hand-worked values.
module tb_uart_rx_byte;

    logic       clock;
    logic       reset;
    logic       sig_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_error;
    logic       overrun;

    int n_checks;
    int n_fail;
    int cyc;
    int fe_cnt;
    int ov_cnt;
    logic [7:0] acc_q[$];
    int         acc_t[$];

    int acc0;
    int fe0;
    int ov0;

    uart_rx_byte #(
        .DATA_WIDTH(8),
        .CLOCK_FREQ(16),
        .BAUD_RATE (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sig_in     (sig_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count rising edges so accept times can be compared.
    always @(posedge clock) begin
        cyc = cyc + 1;
    end

    // Log accepted bytes and every cycle a pulse output is high.
    always @(negedge clock) begin
        if (data_valid && data_ready) begin
            acc_q.push_back(data_out);
            acc_t.push_back(cyc);
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (overrun) ov_cnt = ov_cnt + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp)
        else begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        sig_in = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sig_in = b;
        repeat (16) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic snapshot();
        acc0 = acc_q.size();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        fe_cnt     = 0;
        ov_cnt     = 0;
        reset      = 1'b0;
        sig_in     = 1'b1;
        data_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_output("reset data_out", 32'(data_out), 32'h0);
        check_output("reset data_valid", 32'(data_valid), 32'h0);
        check_output("reset frame_error", 32'(frame_error), 32'h0);
        check_output("reset overrun", 32'(overrun), 32'h0);
        reset = 1'b1;
        idle_cycles(20);

        $display("[TB] basic frame 0xA5");
        data_ready = 1'b1;
        snapshot();
        send_frame(8'hA5, 1'b1);
        idle_cycles(20);
        check_output("basic count", 32'(acc_q.size() - acc0), 32'd1);
        check_output("basic data", 32'(acc_q[$]), 32'hA5);
        check_output("basic frame_error", 32'(fe_cnt - fe0), 32'd0);
        check_output("basic overrun", 32'(ov_cnt - ov0), 32'd0);
        check_output("basic valid cleared", 32'(data_valid), 32'h0);

        $display("[TB] back-to-back 0x00 0xFF 0x3C");
        snapshot();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle_cycles(20);
        check_output("b2b count", 32'(acc_q.size() - acc0), 32'd3);
        if (acc_q.size() - acc0 == 3) begin
            check_output("b2b byte0", 32'(acc_q[acc0]), 32'h00);
            check_output("b2b byte1", 32'(acc_q[acc0 + 1]), 32'hFF);
            check_output("b2b byte2", 32'(acc_q[acc0 + 2]), 32'h3C);
            check_output("b2b spacing01", 32'(acc_t[acc0 + 1] - acc_t[acc0]), 32'd160);
            check_output("b2b spacing12", 32'(acc_t[acc0 + 2] - acc_t[acc0 + 1]), 32'd160);
        end
        check_output("b2b errors", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        $display("[TB] backpressure and overrun");
        data_ready = 1'b0;
        snapshot();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_cycles(20);
        check_output("bp valid held", 32'(data_valid), 32'h1);
        check_output("bp data held", 32'(data_out), 32'h11);
        check_output("bp overrun pulse", 32'(ov_cnt - ov0), 32'd1);
        check_output("bp no accept", 32'(acc_q.size() - acc0), 32'd0);
        data_ready = 1'b1;
        @(posedge clock);
        #1;
        check_output("bp valid falls", 32'(data_valid), 32'h0);
        check_output("bp accepted", 32'(acc_q[$]), 32'h11);
        idle_cycles(40);
        check_output("bp single accept", 32'(acc_q.size() - acc0), 32'd1);

        $display("[TB] framing error and break");
        snapshot();
        send_frame(8'h55, 1'b0);
        sig_in = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        check_output("fe pulse", 32'(fe_cnt - fe0), 32'd1);
        check_output("fe no data", 32'(acc_q.size() - acc0), 32'd0);
        idle_cycles(32);
        send_frame(8'h81, 1'b1);
        idle_cycles(20);
        check_output("fe recover count", 32'(acc_q.size() - acc0), 32'd1);
        check_output("fe recover data", 32'(acc_q[$]), 32'h81);
        check_output("fe no extra error", 32'(fe_cnt - fe0), 32'd1);

        $display("[TB] glitch rejection");
        snapshot();
        sig_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        idle_cycles(40);
        check_output("glitch no data", 32'(acc_q.size() - acc0), 32'd0);
        check_output("glitch no error", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'h7E, 1'b1);
        idle_cycles(20);
        check_output("glitch follow data", 32'(acc_q[$]), 32'h7E);

        $display("[TB] reset mid-frame");
        snapshot();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h99 >> i));
        sig_in = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_output("midrst data_out", 32'(data_out), 32'h0);
        check_output("midrst data_valid", 32'(data_valid), 32'h0);
        check_output("midrst frame_error", 32'(frame_error), 32'h0);
        check_output("midrst overrun", 32'(overrun), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_cycles(40);
        check_output("midrst partial lost", 32'(acc_q.size() - acc0), 32'd0);
        send_frame(8'h42, 1'b1);
        idle_cycles(20);
        check_output("midrst next count", 32'(acc_q.size() - acc0), 32'd1);
        check_output("midrst next data", 32'(acc_q[$]), 32'h42);
        check_output("midrst no error", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
